// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int UART_DW = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  logic          found;
  logic [PW-1:0] idx;

  // Walk N_REQ positions starting at ptr; the first requester found wins.
  always_comb begin
    gnt   = '0;
    any   = |req;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(ptr) + 32'(k)) % 32'(N_REQ));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmit path among byte-stream requesters
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = UART_DW,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [DW-1:0]       w_data,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic                timeout_err
);

  localparam int PW = $clog2(N_REQ);
  // Keep the stall counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] STALL_MAX  = {CW{1'b1}};

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    stall_q, stall_d;
  logic             tout_q, tout_d;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [PW-1:0]    pick_idx;

  logic             locked;
  logic             owner_valid;
  logic             owner_last;
  logic [DW-1:0]    owner_data;
  logic             accept;
  logic             timeout_hit;
  logic [PW-1:0]    next_ptr;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Convert the picker's one-hot grant into the owner index.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) pick_idx = PW'(k);
    end
  end

  // Select the current owner's valid/last/data lanes.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (g_q == PW'(k)) begin
        owner_valid = req_valid[k];
        owner_last  = req_last[k];
        owner_data  = req_data[k*DW +: DW];
      end
    end
  end

  assign locked      = (state_q == LOCK);
  assign accept      = locked && owner_valid && !tx_full;
  assign timeout_hit = (TIMEOUT != 0) && locked && !owner_valid && (stall_q == STALL_LAST);
  assign next_ptr    = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  // Handshake and UART write are combinational so both sides see the same edge.
  assign req_ready   = (locked && !tx_full) ? grant_q : '0;
  assign wr_uart     = accept;
  assign w_data      = locked ? owner_data : '0;
  assign grant       = grant_q;
  assign busy        = locked;
  assign timeout_err = tout_q;

  // Next-state logic: pick an owner in IDLE, release on last byte or stall timeout in LOCK.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    grant_d = grant_q;
    stall_d = stall_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pick_any) begin
          state_d = LOCK;
          g_d     = pick_idx;
          grant_d = pick_gnt;
        end
      end
      LOCK: begin
        if (owner_valid) begin
          // A tx_full stall still counts as activity, so the counter clears.
          stall_d = '0;
          if (accept && owner_last) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
            grant_d = '0;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
          grant_d = '0;
          stall_d = '0;
          tout_d  = 1'b1;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        stall_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      grant_q <= '0;
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart` transmit path among `N_REQ` byte-stream requesters. Each requester presents multi-byte messages on a valid/ready/last interface. The arbiter grants one requester at a time and holds the grant until that requester's `last` byte is accepted. It drives the UART's `wr_uart`/`w_data` inputs directly and respects `tx_full`. A per-grant stall timeout stops a dead requester from locking the UART indefinitely.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DW`, 8: byte width; must equal the UART data width.
- `TIMEOUT`, 1024: cycles a granted requester may hold `req_valid` low mid-message before the grant is revoked; 0 disables the timeout.

- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  N_REQ*DW  requester i's byte is on bits [i*DW +: DW].
- `req_last`  in  N_REQ  marks the final byte of a message; sampled with `req_valid`.
- `req_ready`  out  N_REQ  byte accepted when `req_valid[i] & req_ready[i]`.
- `tx_full`  in  1  from `uart`; no write allowed while high.
- `wr_uart`  out  1  UART write strobe, one per accepted byte.
- `w_data`  out  DW  UART write data.
- `grant`  out  N_REQ  one-hot current owner; all zeros when idle.
- `busy`  out  1  high while in LOCK.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Two states:
  - IDLE: no owner.
  - LOCK: owner index `g` is registered.
- IDLE:
  - If any `req_valid` bit is set, pick the first set bit searching upward (wrapping) from pointer `ptr`.
  - Register `g` and `grant`, then go to LOCK.
  - No byte is accepted in IDLE.
- LOCK, accept rule:
  - `req_ready[g] = !tx_full`; every other `req_ready` bit is 0.
  - `wr_uart = req_valid[g] & !tx_full`.
  - `w_data = req_data[g]`.
  - These are combinational, so the FIFO write and the requester handshake happen on the same edge.
- LOCK, message end: a byte accepted with `req_last[g]=1` sends the arbiter to IDLE and sets `ptr = (g+1) mod N_REQ`.
- LOCK, stall counter:
  - Counts cycles with `req_valid[g]=0`.
  - Clears on any cycle with `req_valid[g]=1`, including cycles where `tx_full` blocks the write.
  - A `tx_full` stall is never a timeout.
- LOCK, timeout: when the stall counter reaches `TIMEOUT-1` with `req_valid[g]` still low:
  - go to IDLE;
  - set `ptr = (g+1) mod N_REQ`;
  - pulse `timeout_err` on the next cycle.
- Non-granted requesters are ignored while in LOCK; their valid may toggle freely.
- Width and wrap:
  - `ptr` is `$clog2(N_REQ)` bits and wraps from N_REQ-1 to 0.
  - The stall counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, `ptr=0`, `grant=0`, `busy=0`, `timeout_err=0`, stall counter 0. Because state is IDLE, `req_ready=0`, `wr_uart=0`, and `w_data=0`.
- Arbitration latency: `req_valid` seen at edge t gives `grant` valid after t+1; the first byte can be accepted in that same cycle if `tx_full=0`.
- Throughput: one byte per cycle while `!tx_full`.
- Between messages there is exactly one IDLE cycle.
- Single-byte message (`last` set on the first byte): LOCK lasts one cycle.
- `tx_full` and `req_valid[g]` both high: no accept, no `wr_uart`, data must be held by the requester, stall counter cleared.
- Reset asserted mid-message: the next edge returns everything to reset values. The partial message is truncated; bytes already written stay in the UART FIFO.
- Timeout and a `valid` rising in the same cycle: `valid` wins, the counter clears, and the grant is kept.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t` {IDLE, LOCK};
  - constant `UART_DW=8`.
- Sub-module `rr_pick` (combinational): inputs `req[N_REQ]` and `ptr`; outputs one-hot `gnt` and `any`. It is reusable by the later RX demux.
- The top holds the state register, `ptr`, the stall counter and the output muxing.

## Test plan
1. Reset release, then requester 0 sends 3 bytes 0x41, 0x42, 0x43 with `last` on 0x43 and `tx_full=0`:
   - `grant` becomes 0001 one cycle after valid;
   - three consecutive `wr_uart` pulses carry 0x41, 0x42, 0x43;
   - IDLE follows, with `ptr=1`.
2. All 4 requesters valid, each sending 1-byte messages 0x10+i, repeated twice:
   - grant order is 0,1,2,3,0,1,2,3;
   - `w_data` sequence is 0x10, 0x11, 0x12, 0x13, then repeats;
   - one idle cycle between grants.
3. `tx_full` held high for 5 cycles mid-message from requester 2:
   - no `wr_uart` and `req_ready[2]=0` for those 5 cycles;
   - no `timeout_err`;
   - the held byte 0x55 is written on the first cycle `tx_full` drops.
4. `TIMEOUT=8`; requester 1 sends 0x61 without `last`, then drops valid:
   - grant is revoked after 8 low cycles;
   - `timeout_err` pulses once;
   - requester 2 (waiting) is granted next.
5. Reset asserted 2 bytes into a 4-byte message from requester 3:
   - the next cycle shows `grant=0`, `wr_uart=0`, `ptr=0`;
   - after reset, requester 0 wins arbitration ahead of requester 3.
6. Loopback with two `uart` instances: messages "AB" from requester 0 and "C" from requester 1 are read back at the far UART as A, B, C in order.
